// File: rtl/common_pkg.sv
// Shared Wishbone bus widths, request payload and initiator state encoding.
package common_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH    = 8;

  typedef struct packed {
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_INIT_IDLE,
    WB_INIT_STROBE,
    WB_INIT_WAIT_ACK
  } wb_init_state_t;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined initiator: turns one valid/ready request into a single-beat
// cycle/strobe exchange and reports read data or a timeout error.
module wb_initiator
  import common_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_data_i,
  output logic                     rsp_valid_o,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wbp_addr_o,
  output logic [DATA_WIDTH-1:0]    wbp_data_o,
  output logic                     wbp_we_o,
  output logic                     wbp_sel_o,
  output logic                     wbp_cycle_o,
  output logic                     wbp_strobe_o,
  input  logic [DATA_WIDTH-1:0]    wbp_data_i,
  input  logic                     wbp_stall_i,
  input  logic                     wbp_ack_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] IDLE_DATA = {DATA_WIDTH{1'b1}};

  wb_init_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  wb_req_t               req_q, req_d;
  logic                  cycle_q, cycle_d;
  logic                  strobe_q, strobe_d;
  logic                  sel_q, sel_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  timed_out, finish_ok, finish_err;

  // Next state, counter and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    cycle_d     = cycle_q;
    strobe_d    = strobe_q;
    sel_d       = sel_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    finish_ok   = 1'b0;
    finish_err  = 1'b0;
    cnt_inc     = cnt_q + CNT_W'(1);
    // The abort fires on the edge where the running count reaches the limit.
    timed_out   = (cnt_inc == CNT_MAX);

    unique case (state_q)
      WB_INIT_IDLE: begin
        ready_d = 1'b1;
        if (req_valid_i && ready_q) begin
          req_d    = '{we: req_we_i, addr: req_addr_i, data: req_data_i};
          cycle_d  = 1'b1;
          strobe_d = 1'b1;
          sel_d    = 1'b1;
          ready_d  = 1'b0;
          cnt_d    = '0;
          state_d  = WB_INIT_STROBE;
        end
      end
      WB_INIT_STROBE: begin
        cnt_d = cnt_inc;
        if (!wbp_stall_i && wbp_ack_i) begin
          finish_ok = 1'b1;
        end else if (timed_out) begin
          finish_err = 1'b1;
        end else if (!wbp_stall_i) begin
          strobe_d = 1'b0;
          state_d  = WB_INIT_WAIT_ACK;
        end
      end
      WB_INIT_WAIT_ACK: begin
        cnt_d = cnt_inc;
        if (wbp_ack_i) begin
          finish_ok = 1'b1;
        end else if (timed_out) begin
          finish_err = 1'b1;
        end
      end
      default: state_d = WB_INIT_IDLE;
    endcase

    // Ack takes priority over timeout because finish_ok is decided first above.
    if (finish_ok || finish_err) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = finish_err;
      cycle_d     = 1'b0;
      strobe_d    = 1'b0;
      sel_d       = 1'b0;
      ready_d     = 1'b1;
      state_d     = WB_INIT_IDLE;
      if (finish_err) begin
        rsp_data_d = IDLE_DATA;
      end else if (!req_q.we) begin
        rsp_data_d = wbp_data_i;
      end
    end
  end

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state_q     <= WB_INIT_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      cycle_q     <= 1'b0;
      strobe_q    <= 1'b0;
      sel_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= IDLE_DATA;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      cycle_q     <= cycle_d;
      strobe_q    <= strobe_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_data_o   = rsp_data_q;
  assign wbp_addr_o   = req_q.addr;
  assign wbp_data_o   = req_q.data;
  assign wbp_we_o     = req_q.we;
  assign wbp_sel_o    = sel_q;
  assign wbp_cycle_o  = cycle_q;
  assign wbp_strobe_o = strobe_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a table of transactions, random traffic and reset/back-to-back
// sequences, all checked against a latency/timeout model and a peripheral memory model.
module tb_wb_initiator;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_i, req_ready_o, req_we_i;
  logic [7:0] req_addr_i, req_data_i;
  logic       rsp_valid_o, rsp_err_o;
  logic [7:0] rsp_data_o;
  logic [7:0] wbp_addr_o, wbp_data_o;
  logic       wbp_we_o, wbp_sel_o, wbp_cycle_o, wbp_strobe_o;
  logic [7:0] wbp_data_i;
  logic       wbp_stall_i, wbp_ack_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] last_rsp;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    int         s;
    int         d;
    bit         never;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clock_i  (clk),
    .wb_reset_i  (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .wbp_addr_o  (wbp_addr_o),
    .wbp_data_o  (wbp_data_o),
    .wbp_we_o    (wbp_we_o),
    .wbp_sel_o   (wbp_sel_o),
    .wbp_cycle_o (wbp_cycle_o),
    .wbp_strobe_o(wbp_strobe_o),
    .wbp_data_i  (wbp_data_i),
    .wbp_stall_i (wbp_stall_i),
    .wbp_ack_i   (wbp_ack_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction; the responder stalls s cycles then acks d cycles after the strobe is taken.
  task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                     input int s, input int d, input bit never, output int waited);
    int lat, e;
    bit ok;
    logic [7:0] exp_data;
    waited = 0;
    while (req_ready_o !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk("ready_before_req", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_data_i  = wdata;
    wbp_stall_i = 1'($urandom_range(0, 1));
    wbp_ack_i   = 1'($urandom_range(0, 1));
    wbp_data_i  = 8'($urandom);
    lat = 1 + s + d;
    ok  = !never && (lat <= T);
    e   = ok ? lat : T;
    step();
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom_range(0, 1));
    req_addr_i  = 8'($urandom);
    req_data_i  = 8'($urandom);
    chk("accept_cycle", 32'(wbp_cycle_o), 32'd1);
    chk("accept_strobe", 32'(wbp_strobe_o), 32'd1);
    chk("accept_sel", 32'(wbp_sel_o), 32'd1);
    chk("accept_we", 32'(wbp_we_o), 32'(we));
    chk("accept_addr", 32'(wbp_addr_o), 32'(addr));
    chk("accept_wdata", 32'(wbp_data_o), 32'(wdata));
    chk("accept_ready", 32'(req_ready_o), 32'd0);
    chk("accept_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("rsp_data_hold", 32'(rsp_data_o), 32'(last_rsp));
    for (int k = 1; k <= e; k++) begin
      wbp_stall_i = (k <= s);
      wbp_ack_i   = !never && (k == lat);
      wbp_data_i  = (!never && k == lat && !we) ? mem[addr] : 8'($urandom);
      step();
      if (k == e) begin
        if (!ok) exp_data = 8'hFF;
        else if (we) exp_data = last_rsp;
        else exp_data = mem[addr];
        if (ok && we) mem[addr] = wdata;
        chk("done_valid", 32'(rsp_valid_o), 32'd1);
        chk("done_err", 32'(rsp_err_o), 32'(!ok));
        chk("done_data", 32'(rsp_data_o), 32'(exp_data));
        chk("done_cycle", 32'(wbp_cycle_o), 32'd0);
        chk("done_strobe", 32'(wbp_strobe_o), 32'd0);
        chk("done_ready", 32'(req_ready_o), 32'd1);
        last_rsp = exp_data;
      end else begin
        chk("busy_no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("busy_cycle", 32'(wbp_cycle_o), 32'd1);
        chk("busy_strobe", 32'(wbp_strobe_o), 32'(k <= s));
        chk("busy_addr", 32'(wbp_addr_o), 32'(addr));
        chk("busy_wdata", 32'(wbp_data_o), 32'(wdata));
        chk("busy_ready", 32'(req_ready_o), 32'd0);
      end
    end
    wbp_ack_i   = 1'b0;
    wbp_stall_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    last_rsp = 8'hFF;
    vecs[0]  = '{1'b1, 8'd3, 8'h53, 0, 1, 1'b0};
    vecs[1]  = '{1'b0, 8'd3, 8'h00, 0, 1, 1'b0};
    vecs[2]  = '{1'b0, 8'd3, 8'h00, 3, 1, 1'b0};
    vecs[3]  = '{1'b1, 8'd5, 8'hA5, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 8'd5, 8'h00, 1, 0, 1'b0};
    vecs[5]  = '{1'b0, 8'd7, 8'h00, 0, 7, 1'b0};
    vecs[6]  = '{1'b0, 8'd7, 8'h00, 0, 8, 1'b0};
    vecs[7]  = '{1'b1, 8'd9, 8'h3C, 0, 0, 1'b1};
    vecs[8]  = '{1'b0, 8'd1, 8'h00, 12, 0, 1'b1};
    vecs[9]  = '{1'b1, 8'd7, 8'h11, 7, 0, 1'b0};
    vecs[10] = '{1'b0, 8'd7, 8'h00, 2, 1, 1'b0};

    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    wbp_data_i = '0; wbp_stall_i = 1'b0; wbp_ack_i = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    chk("rst_data", 32'(rsp_data_o), 32'hFF);
    chk("rst_cycle", 32'(wbp_cycle_o), 32'd0);
    chk("rst_strobe", 32'(wbp_strobe_o), 32'd0);
    chk("rst_we", 32'(wbp_we_o), 32'd0);
    chk("rst_sel", 32'(wbp_sel_o), 32'd0);
    chk("rst_addr", 32'(wbp_addr_o), 32'd0);
    chk("rst_wdata", 32'(wbp_data_o), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);

    // Power-on reads of an untouched peripheral.
    for (int a = 0; a < 10; a++) txn(1'b0, 8'(a), 8'h00, 0, 1, 1'b0, w);

    for (int i = 0; i < 11; i++)
      txn(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].s, vecs[i].d, vecs[i].never, w);

    // Back-to-back: the second request is taken on the first one's completion cycle.
    txn(1'b1, 8'd20, 8'h77, 0, 1, 1'b0, w);
    txn(1'b0, 8'd20, 8'h00, 1, 1, 1'b0, w);
    chk("b2b_no_wait", 32'(w), 32'd0);

    // Reset while waiting for ack.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 8'd4; req_data_i = 8'h00;
    step();
    req_valid_i = 1'b0;
    wbp_stall_i = 1'b0;
    step();
    chk("mid_wait_cycle", 32'(wbp_cycle_o), 32'd1);
    chk("mid_wait_strobe", 32'(wbp_strobe_o), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cycle", 32'(wbp_cycle_o), 32'd0);
    chk("mid_rst_strobe", 32'(wbp_strobe_o), 32'd0);
    chk("mid_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
    wbp_ack_i = 1'b1;
    wbp_data_i = 8'h5A;
    step();
    wbp_ack_i = 1'b0;
    chk("post_mid_rst_ready", 32'(req_ready_o), 32'd1);
    chk("post_mid_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("post_mid_rst_cycle", 32'(wbp_cycle_o), 32'd0);
    chk("post_mid_rst_data", 32'(rsp_data_o), 32'hFF);
    last_rsp = 8'hFF;

    for (int i = 0; i < 40; i++)
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
          ($urandom_range(0, 7) == 0), w);

    step();
    chk("final_idle_cycle", 32'(wbp_cycle_o), 32'd0);
    chk("final_no_rsp", 32'(rsp_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
